// File: rtl/ts_os_parser_pkg.sv
// rtl/ts_os_parser_pkg.sv - shared symbols, parser state and TS field record
// Purpose: ordered-set symbol constants, the parser state encoding and the
//   packed record of TS1/TS2 fields used by the lane parser and its bench.
// Ports: none (package).
package pcie_os_pkg;

  localparam logic [7:0] COM    = 8'hBC;  // K symbol
  localparam logic [7:0] PAD    = 8'hF7;  // K symbol
  localparam logic [7:0] TS1_ID = 8'h4A;  // data symbol
  localparam logic [7:0] TS2_ID = 8'h45;  // data symbol
  localparam int         TS_ID_LEN = 10;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LINK,
    ST_LANE,
    ST_NFTS,
    ST_RATE,
    ST_CTRL,
    ST_ID
  } os_state_e;

  typedef struct packed {
    logic       ts_type;     // 0 = TS1, 1 = TS2
    logic       link_pad;
    logic [7:0] link_num;
    logic       lane_pad;
    logic [7:0] lane_num;
    logic [7:0] nfts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_fields_t;

  // Two TSs are "identical" for consecutive counting when every field except
  // N_FTS matches; N_FTS may legally vary between otherwise equal TSs.
  function automatic logic same_key(input ts_fields_t a, input ts_fields_t b);
    ts_fields_t ka;
    ts_fields_t kb;
    ka      = a;
    kb      = b;
    ka.nfts = '0;
    kb.nfts = '0;
    return ka == kb;
  endfunction

endpackage

// File: rtl/ts_os_parser_if.sv
// rtl/ts_os_parser_if.sv - PIPE lane receive inputs and parsed TS outputs
// Purpose: bundles one lane's PIPE receive symbols plus the parser results.
// Ports: master drives RxData/RxDataK/RxValid/RxStatus/consec_clr and reads
//   the results; slave (the parser) reads the symbols and drives ts_valid,
//   the ts_* fields, consec_cnt and os_error.
interface ts_os_parser_if #(
  parameter int CNT_WIDTH = 4
);
  logic [7:0]           RxData;
  logic                 RxDataK;
  logic                 RxValid;
  logic [2:0]           RxStatus;
  logic                 consec_clr;

  logic                 ts_valid;
  logic                 ts_type;
  logic [7:0]           ts_link_num;
  logic                 ts_link_pad;
  logic [7:0]           ts_lane_num;
  logic                 ts_lane_pad;
  logic [7:0]           ts_nfts;
  logic [7:0]           ts_rate_id;
  logic [7:0]           ts_train_ctrl;
  logic [CNT_WIDTH-1:0] consec_cnt;
  logic                 os_error;

  modport master (
    output RxData, RxDataK, RxValid, RxStatus, consec_clr,
    input  ts_valid, ts_type, ts_link_num, ts_link_pad, ts_lane_num,
           ts_lane_pad, ts_nfts, ts_rate_id, ts_train_ctrl, consec_cnt,
           os_error
  );

  modport slave (
    input  RxData, RxDataK, RxValid, RxStatus, consec_clr,
    output ts_valid, ts_type, ts_link_num, ts_link_pad, ts_lane_num,
           ts_lane_pad, ts_nfts, ts_rate_id, ts_train_ctrl, consec_cnt,
           os_error
  );
endinterface

// File: rtl/ts_os_parser.sv
// rtl/ts_os_parser.sv - per-lane Gen1/Gen2 TS1/TS2 ordered-set parser
// Purpose: walks COM, link, lane, N_FTS, rate, control and ten identifier
//   symbols; on a well-formed set pulses ts_valid with the latched fields and
//   updates the count of consecutive identical TSs; pulses os_error when a
//   set in progress is aborted.
// Ports: pclk (rising edge), reset_n (async, active low), rx (slave modport)
//   carrying the PIPE symbol inputs, consec_clr and all parser outputs.
module ts_os_parser
  import pcie_os_pkg::*;
#(
  parameter int CNT_WIDTH = 4,
  parameter int CNT_SAT   = 15
) (
  input  logic          pclk,
  input  logic          reset_n,
  ts_os_parser_if.slave rx
);

  localparam logic [CNT_WIDTH-1:0] SAT     = CNT_WIDTH'(CNT_SAT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [3:0]           ID_LAST = 4'(TS_ID_LEN - 1);

  os_state_e            state_q,      state_d;
  logic [3:0]           id_idx_q,     id_idx_d;
  logic [7:0]           id_sym_q,     id_sym_d;
  ts_fields_t           work_q,       work_d;
  ts_fields_t           out_q,        out_d;
  logic                 ts_valid_q,   ts_valid_d;
  logic                 os_error_q,   os_error_d;
  logic                 hist_valid_q, hist_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;

  logic sym_ok;
  logic sym_bad;
  logic is_com;
  logic is_pad;
  logic abort;
  logic ts_done;
  logic status_unused;

  assign sym_ok        = rx.RxValid & ~rx.RxStatus[2];
  assign sym_bad       = rx.RxValid &  rx.RxStatus[2];
  assign is_com        = rx.RxDataK && (rx.RxData == COM);
  assign is_pad        = rx.RxDataK && (rx.RxData == PAD);
  assign status_unused = ^rx.RxStatus[1:0];

  // Symbol-level parse.
  always_comb begin
    state_d    = state_q;
    id_idx_d   = id_idx_q;
    id_sym_d   = id_sym_q;
    work_d     = work_q;
    os_error_d = 1'b0;
    ts_done    = 1'b0;
    abort      = 1'b0;

    if (state_q == ST_HUNT) begin
      if (sym_ok && is_com) begin
        state_d  = ST_LINK;
        work_d   = '0;
        id_idx_d = '0;
      end
    end else if (sym_bad) begin
      abort = 1'b1;
    end else if (sym_ok && is_com) begin
      // A COM mid-set kills the current set but starts the next one.
      os_error_d = 1'b1;
      state_d    = ST_LINK;
      work_d     = '0;
      id_idx_d   = '0;
    end else if (sym_ok) begin
      case (state_q)
        ST_LINK: begin
          if (is_pad) begin
            work_d.link_pad = 1'b1;
            work_d.link_num = '0;
            state_d         = ST_LANE;
          end else if (!rx.RxDataK) begin
            work_d.link_num = rx.RxData;
            state_d         = ST_LANE;
          end else begin
            abort = 1'b1;
          end
        end
        ST_LANE: begin
          if (is_pad) begin
            work_d.lane_pad = 1'b1;
            work_d.lane_num = '0;
            state_d         = ST_NFTS;
          end else if (!rx.RxDataK) begin
            work_d.lane_num = rx.RxData;
            state_d         = ST_NFTS;
          end else begin
            abort = 1'b1;
          end
        end
        ST_NFTS: begin
          if (rx.RxDataK) abort = 1'b1;
          else begin
            work_d.nfts = rx.RxData;
            state_d     = ST_RATE;
          end
        end
        ST_RATE: begin
          if (rx.RxDataK) abort = 1'b1;
          else begin
            work_d.rate_id = rx.RxData;
            state_d        = ST_CTRL;
          end
        end
        ST_CTRL: begin
          if (rx.RxDataK) abort = 1'b1;
          else begin
            work_d.train_ctrl = rx.RxData;
            state_d           = ST_ID;
            id_idx_d          = '0;
          end
        end
        ST_ID: begin
          if (rx.RxDataK) begin
            abort = 1'b1;
          end else if (id_idx_q == '0) begin
            // The first identifier decides TS1 vs TS2; the rest must repeat it.
            if (rx.RxData == TS1_ID || rx.RxData == TS2_ID) begin
              work_d.ts_type = (rx.RxData == TS2_ID);
              id_sym_d       = rx.RxData;
              id_idx_d       = 4'd1;
            end else begin
              abort = 1'b1;
            end
          end else if (rx.RxData != id_sym_q) begin
            abort = 1'b1;
          end else if (id_idx_q == ID_LAST) begin
            ts_done  = 1'b1;
            state_d  = ST_HUNT;
            id_idx_d = '0;
          end else begin
            id_idx_d = id_idx_q + 4'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (abort) begin
      os_error_d = 1'b1;
      state_d    = ST_HUNT;
      id_idx_d   = '0;
    end
  end

  // Result publication and consecutive-TS history. The last published
  // fields double as the comparison key; hist_valid says whether they count.
  always_comb begin
    out_d        = out_q;
    cnt_d        = cnt_q;
    hist_valid_d = hist_valid_q;
    ts_valid_d   = ts_done;
    if (ts_done) begin
      out_d        = work_q;
      hist_valid_d = 1'b1;
      // A clear coinciding with completion makes this TS the first of a run.
      if (hist_valid_q && !rx.consec_clr && same_key(work_q, out_q))
        cnt_d = (cnt_q >= SAT) ? SAT : cnt_q + CNT_ONE;
      else
        cnt_d = CNT_ONE;
    end else if (rx.consec_clr) begin
      cnt_d        = '0;
      hist_valid_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HUNT;
      id_idx_q     <= '0;
      id_sym_q     <= '0;
      work_q       <= '0;
      out_q        <= '0;
      ts_valid_q   <= 1'b0;
      os_error_q   <= 1'b0;
      hist_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      id_idx_q     <= id_idx_d;
      id_sym_q     <= id_sym_d;
      work_q       <= work_d;
      out_q        <= out_d;
      ts_valid_q   <= ts_valid_d;
      os_error_q   <= os_error_d;
      hist_valid_q <= hist_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rx.ts_valid      = ts_valid_q;
  assign rx.ts_type       = out_q.ts_type;
  assign rx.ts_link_num   = out_q.link_num;
  assign rx.ts_link_pad   = out_q.link_pad;
  assign rx.ts_lane_num   = out_q.lane_num;
  assign rx.ts_lane_pad   = out_q.lane_pad;
  assign rx.ts_nfts       = out_q.nfts;
  assign rx.ts_rate_id    = out_q.rate_id;
  assign rx.ts_train_ctrl = out_q.train_ctrl;
  assign rx.consec_cnt    = cnt_q;
  assign rx.os_error      = os_error_q;

endmodule

// File: tb/tb_ts_os_parser.sv
// tb/tb_ts_os_parser.sv - self-checking bench for ts_os_parser
module tb_ts_os_parser;
  import pcie_os_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic pclk    = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  ts_os_parser_if #(.CNT_WIDTH(CW)) bus ();

  ts_os_parser #(.CNT_WIDTH(CW), .CNT_SAT(CNT_MAX)) dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .rx      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  ts_fields_t mon_f[$];
  int         mon_cnt[$];
  int         mon_cyc[$];
  int         err_seen = 0;

  function automatic ts_fields_t out_fields();
    return {bus.ts_type, bus.ts_link_pad, bus.ts_link_num, bus.ts_lane_pad,
            bus.ts_lane_num, bus.ts_nfts, bus.ts_rate_id, bus.ts_train_ctrl};
  endfunction

  always @(negedge pclk) begin
    if (reset_n) begin
      if (bus.ts_valid) begin
        mon_f.push_back(out_fields());
        mon_cnt.push_back(int'(bus.consec_cnt));
        mon_cyc.push_back(cyc);
      end
      if (bus.os_error) err_seen++;
    end
  end

  // Reference model of the consecutive-TS rule.
  bit         m_hist;
  ts_fields_t m_key;
  int         m_cnt;

  function automatic int model_done(input ts_fields_t f, input bit clr);
    ts_fields_t k;
    k      = f;
    k.nfts = 8'h00;
    if (m_hist && !clr && k == m_key) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    else m_cnt = 1;
    m_key  = k;
    m_hist = 1'b1;
    return m_cnt;
  endfunction

  function automatic void model_clr();
    m_hist = 1'b0;
    m_cnt  = 0;
  endfunction

  // Symbol i (0..15) of a well-formed TS carrying f, as {K, data}.
  function automatic logic [8:0] ts_sym(input ts_fields_t f, input int i);
    case (i)
      0:       return {1'b1, COM};
      1:       return f.link_pad ? {1'b1, PAD} : {1'b0, f.link_num};
      2:       return f.lane_pad ? {1'b1, PAD} : {1'b0, f.lane_num};
      3:       return {1'b0, f.nfts};
      4:       return {1'b0, f.rate_id};
      5:       return {1'b0, f.train_ctrl};
      default: return {1'b0, f.ts_type ? TS2_ID : TS1_ID};
    endcase
  endfunction

  function automatic ts_fields_t rand_ts();
    ts_fields_t f;
    f.ts_type    = 1'($urandom);
    f.link_pad   = ($urandom_range(3) == 0);
    f.link_num   = f.link_pad ? 8'h00 : 8'($urandom_range(3));
    f.lane_pad   = ($urandom_range(3) == 0);
    f.lane_num   = f.lane_pad ? 8'h00 : 8'($urandom_range(3));
    f.nfts       = 8'($urandom);
    f.rate_id    = 8'($urandom_range(2, 1));
    f.train_ctrl = 8'($urandom_range(1));
    return f;
  endfunction

  task automatic drive(input logic [7:0] d, input logic k, input logic v,
                       input logic [2:0] s, input logic clr);
    bus.RxData     = d;
    bus.RxDataK    = k;
    bus.RxValid    = v;
    bus.RxStatus   = s;
    bus.consec_clr = clr;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'($urandom), 1'($urandom), 1'b0, 3'($urandom), 1'b0);
  endtask

  task automatic send_sym(input logic [8:0] s, input logic clr);
    drive(s[7:0], s[8], 1'b1, 3'b000, clr);
  endtask

  // err_kind: 0 clean, 1 identifier change at ID index 5, 2 bad status at the
  // rate symbol, 3 COM at the control symbol followed by a full clean set.
  task automatic run_ts(input ts_fields_t f, input int err_kind, input int gap_pos,
                        input int gap_len, input int gap_pct, input bit clr_last,
                        output int n_vld, output ts_fields_t got_f, output int got_cnt,
                        output int lat, output int n_err, output int gaps);
    int         i;
    int         com_cyc;
    int         kind;
    logic [8:0] s;
    kind = err_kind;
    mon_f.delete();
    mon_cnt.delete();
    mon_cyc.delete();
    err_seen = 0;
    gaps     = 0;
    send_sym(ts_sym(f, 0), 1'b0);
    com_cyc = cyc;
    i = 1;
    while (i < 16) begin
      if (i == gap_pos) begin
        idle(gap_len);
        gaps += gap_len;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        idle(1);
        gaps++;
      end
      s = ts_sym(f, i);
      if (kind == 1 && i == 11) begin
        drive(f.ts_type ? TS1_ID : TS2_ID, 1'b0, 1'b1, 3'b000, 1'b0);
        break;
      end else if (kind == 2 && i == 4) begin
        drive(s[7:0], s[8], 1'b1, {1'b1, 2'($urandom)}, 1'b0);
        break;
      end else if (kind == 3 && i == 5) begin
        send_sym(ts_sym(f, 0), 1'b0);
        com_cyc = cyc;
        gaps    = 0;
        kind    = 0;
        i       = 1;
      end else begin
        send_sym(s, clr_last && (i == 15));
        i++;
      end
    end
    idle(3);
    n_vld   = mon_f.size();
    n_err   = err_seen;
    got_f   = '0;
    got_cnt = -1;
    lat     = -1;
    if (n_vld > 0) begin
      got_f   = mon_f[0];
      got_cnt = mon_cnt[0];
      lat     = mon_cyc[0] - com_cyc;
    end
  endtask

  ts_fields_t ts1_ref;
  int n_vld, got_cnt, lat, n_err, gaps, exp_cnt;
  ts_fields_t got_f;

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++; if ({bus.ts_valid, bus.os_error} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bus.ts_valid, bus.os_error}); end
    checks++; if (out_fields() !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", out_fields()); end
    checks++; if (bus.consec_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.consec_cnt); end
    reset_n = 1'b1;
    err_seen = 0;
    idle(4);
    checks++; if (err_seen !== 0 || bus.consec_cnt !== 4'd0) begin failures++; $display("FAIL idle_quiet got_err=%0d got_cnt=%0d exp=0", err_seen, bus.consec_cnt); end
  endtask

  task automatic test_clean_ts1();
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    checks++; if (n_vld !== 1) begin failures++; $display("FAIL clean_vld_pulses got=%0d exp=1", n_vld); end
    checks++; if (got_f !== ts1_ref) begin failures++; $display("FAIL clean_fields got=%h exp=%h", got_f, ts1_ref); end
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL clean_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
    checks++; if (lat !== 15) begin failures++; $display("FAIL clean_latency got=%0d exp=15", lat); end
    checks++; if (n_err !== 0) begin failures++; $display("FAIL clean_os_error got=%0d exp=0", n_err); end
  endtask

  task automatic test_back_to_back();
    ts_fields_t f;
    int exp_c[17];
    drive(8'h00, 1'b0, 1'b0, 3'b000, 1'b1);
    model_clr();
    mon_f.delete(); mon_cnt.delete(); mon_cyc.delete();
    err_seen = 0;
    f = ts1_ref;
    for (int n = 0; n < 17; n++) begin
      f.nfts   = 8'($urandom);
      exp_c[n] = model_done(f, 1'b0);
      for (int i = 0; i < 16; i++) send_sym(ts_sym(f, i), 1'b0);
    end
    idle(3);
    checks++; if (mon_cnt.size() !== 17) begin failures++; $display("FAIL b2b_count got=%0d exp=17", mon_cnt.size()); end
    for (int n = 0; n < 17; n++) begin
      if (n < mon_cnt.size()) begin
        checks++; if (mon_cnt[n] !== exp_c[n]) begin failures++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", n, mon_cnt[n], exp_c[n]); end
      end
    end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL b2b_os_error got=%0d exp=0", err_seen); end
    f = '{ts_type: 1'b1, link_pad: 1'b1, link_num: 8'h00, lane_pad: 1'b1, lane_num: 8'h00,
          nfts: 8'h20, rate_id: 8'h02, train_ctrl: 8'h00};
    run_ts(f, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(f, 1'b0);
    checks++; if (got_f !== f) begin failures++; $display("FAIL ts2_pad_fields got=%h exp=%h", got_f, f); end
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL ts2_pad_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
  endtask

  task automatic test_id_mismatch();
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    run_ts(ts1_ref, 1, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    checks++; if (n_vld !== 0) begin failures++; $display("FAIL idchg_vld got=%0d exp=0", n_vld); end
    checks++; if (n_err !== 1) begin failures++; $display("FAIL idchg_os_error got=%0d exp=1", n_err); end
    checks++; if (out_fields() !== ts1_ref) begin failures++; $display("FAIL idchg_fields_held got=%h exp=%h", out_fields(), ts1_ref); end
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    checks++; if (n_vld !== 1 || got_cnt !== exp_cnt) begin failures++; $display("FAIL idchg_next_cnt got=%0d/%0d exp=1/%0d", n_vld, got_cnt, exp_cnt); end
  endtask

  task automatic test_bad_status_and_hold();
    run_ts(ts1_ref, 2, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    checks++; if (n_vld !== 0 || n_err !== 1) begin failures++; $display("FAIL badstat got_vld=%0d got_err=%0d exp=0/1", n_vld, n_err); end
    checks++; if (int'(bus.consec_cnt) !== m_cnt) begin failures++; $display("FAIL badstat_cnt_held got=%0d exp=%0d", bus.consec_cnt, m_cnt); end
    run_ts(ts1_ref, 0, 9, 3, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    checks++; if (n_err !== 0 || n_vld !== 1) begin failures++; $display("FAIL hold_result got_err=%0d got_vld=%0d exp=0/1", n_err, n_vld); end
    checks++; if (lat !== 18) begin failures++; $display("FAIL hold_latency got=%0d exp=18", lat); end
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
  endtask

  task automatic test_com_resync();
    ts_fields_t f;
    f = rand_ts();
    run_ts(f, 3, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(f, 1'b0);
    checks++; if (n_err !== 1) begin failures++; $display("FAIL resync_os_error got=%0d exp=1", n_err); end
    checks++; if (n_vld !== 1 || got_f !== f) begin failures++; $display("FAIL resync_fields got=%h exp=%h", got_f, f); end
    checks++; if (lat !== 15 || got_cnt !== exp_cnt) begin failures++; $display("FAIL resync_lat_cnt got=%0d/%0d exp=15/%0d", lat, got_cnt, exp_cnt); end
  endtask

  task automatic test_consec_clr();
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b1, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b1);
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL clr_coincident_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
    drive(8'h00, 1'b0, 1'b0, 3'b000, 1'b1);
    model_clr();
    checks++; if (int'(bus.consec_cnt) !== m_cnt) begin failures++; $display("FAIL clr_alone_cnt got=%0d exp=%0d", bus.consec_cnt, m_cnt); end
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL clr_after_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_lane();
    send_sym(ts_sym(ts1_ref, 0), 1'b0);
    send_sym(ts_sym(ts1_ref, 1), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_fields() !== '0 || bus.consec_cnt !== 4'd0) begin failures++; $display("FAIL async_reset got=%h/%0d exp=0/0", out_fields(), bus.consec_cnt); end
    idle(2);
    reset_n = 1'b1;
    model_clr();
    mon_f.delete(); mon_cnt.delete(); mon_cyc.delete();
    err_seen = 0;
    for (int i = 2; i < 16; i++) send_sym(ts_sym(ts1_ref, i), 1'b0);
    idle(3);
    checks++; if (mon_f.size() !== 0 || err_seen !== 0) begin failures++; $display("FAIL partial_after_reset got_vld=%0d got_err=%0d exp=0/0", mon_f.size(), err_seen); end
    run_ts(ts1_ref, 0, -1, 0, 0, 1'b0, n_vld, got_f, got_cnt, lat, n_err, gaps);
    exp_cnt = model_done(ts1_ref, 1'b0);
    checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL post_reset_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    ts_fields_t f;
    ts_fields_t prev;
    int kind;
    int sel;
    bit clr;
    prev = rand_ts();
    for (int n = 0; n < 40; n++) begin
      f      = ($urandom_range(1) == 0) ? prev : rand_ts();
      f.nfts = 8'($urandom);
      sel    = int'($urandom_range(9));
      kind   = (sel < 3) ? sel + 1 : 0;
      clr    = ($urandom_range(9) == 0);
      if ($urandom_range(9) == 0) begin
        drive(8'($urandom), 1'($urandom), 1'b0, 3'b000, 1'b1);
        model_clr();
        checks++; if (int'(bus.consec_cnt) !== m_cnt) begin failures++; $display("FAIL rnd_clr[%0d] got=%0d exp=%0d", n, bus.consec_cnt, m_cnt); end
      end
      run_ts(f, kind, -1, 0, 15, clr, n_vld, got_f, got_cnt, lat, n_err, gaps);
      if (kind == 1 || kind == 2) begin
        checks++; if (n_vld !== 0 || n_err !== 1) begin failures++; $display("FAIL rnd_abort[%0d] kind=%0d got_vld=%0d got_err=%0d exp=0/1", n, kind, n_vld, n_err); end
      end else begin
        exp_cnt = model_done(f, clr);
        checks++; if (n_vld !== 1 || got_f !== f) begin failures++; $display("FAIL rnd_fields[%0d] got=%h (%0d) exp=%h", n, got_f, n_vld, f); end
        checks++; if (got_cnt !== exp_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, got_cnt, exp_cnt); end
        checks++; if (lat !== 15 + gaps) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", n, lat, 15 + gaps); end
        checks++; if (n_err !== ((kind == 3) ? 1 : 0)) begin failures++; $display("FAIL rnd_os_error[%0d] got=%0d exp=%0d", n, n_err, (kind == 3) ? 1 : 0); end
      end
      prev = f;
    end
  endtask

  initial begin
    bus.RxData     = 8'h00;
    bus.RxDataK    = 1'b0;
    bus.RxValid    = 1'b0;
    bus.RxStatus   = 3'b000;
    bus.consec_clr = 1'b0;
    m_hist = 1'b0;
    m_cnt  = 0;
    m_key  = '0;
    ts1_ref = '{ts_type: 1'b0, link_pad: 1'b0, link_num: 8'h00, lane_pad: 1'b0, lane_num: 8'h03,
                nfts: 8'hFF, rate_id: 8'h02, train_ctrl: 8'h00};
    test_reset();
    test_clean_ts1();
    test_back_to_back();
    test_id_mismatch();
    test_bad_status_and_hold();
    test_com_resync();
    test_consec_clr();
    test_reset_mid_lane();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
